// File: rtl/serial_subtractor.sv
// Bit-serial a - b (a + ~b + 1), one bit per cycle LSB first; done_o pulses WIDTH cycles after start.
// No backpressure: start_i is ignored while busy, and a start in the DONE cycle is taken back-to-back.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             borrow_o,
   output logic             ovf_o
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;

   logic bit_a, bit_nb, sum_bit, carry_out;

   // Single full-adder cell operating on the current LSBs of the shift registers.
   assign bit_a     = a_q[0];
   assign bit_nb    = ~b_q[0];
   assign sum_bit   = bit_a ^ bit_nb ^ carry_q;
   assign carry_out = (bit_a & bit_nb) | (bit_a & carry_q) | (bit_nb & carry_q);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;

      case (state_q)
         S_RUN: begin
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            res_d   = {sum_bit, res_q[WIDTH-1:1]};
            carry_d = carry_out;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               // carry_q here is the carry into the MSB; carry_out is the final carry.
               diff_d   = {sum_bit, res_q[WIDTH-1:1]};
               borrow_d = ~carry_out;
               ovf_d    = carry_q ^ carry_out;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               state_d  = S_DONE;
            end
         end
         default: begin
            if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
            if (start_i) begin
               a_d     = a_i;
               b_d     = b_i;
               res_d   = '0;
               carry_d = 1'b1;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign diff_o   = diff_q;
   assign borrow_o = borrow_q;
   assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with hand-computed expected results.
module tb_serial_subtractor;

   localparam int W = 8;
   localparam int MAX_WAIT = 30;

   logic         clk_i;
   logic         rst_ni;
   logic         start_i;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         busy_o;
   logic         done_o;
   logic [W-1:0] diff_o;
   logic         borrow_o;
   logic         ovf_o;

   int n_checks = 0;
   int n_pass   = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .start_i  (start_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .diff_o   (diff_o),
      .borrow_o (borrow_o),
      .ovf_o    (ovf_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Present operands with start for one edge; returns #1 after that start edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk_i);
      start_i = 1'b1;
      a_i     = a;
      b_i     = b;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      a_i     = 8'hAA;
      b_i     = 8'h55;
   endtask

   // Counts edges after the start edge until done_o is seen, bounded by MAX_WAIT.
   task automatic wait_done(output int cyc);
      cyc = MAX_WAIT;
      for (int i = 1; i <= MAX_WAIT; i++) begin
         @(posedge clk_i);
         #1;
         if (done_o) begin
            cyc = i;
            break;
         end
      end
   endtask

   logic [W-1:0] vec_a   [6] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h00, 8'hFF};
   logic [W-1:0] vec_b   [6] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h00, 8'hFF};
   logic [W-1:0] exp_d   [6] = '{8'h02, 8'hFE, 8'h7F, 8'h80, 8'h00, 8'h00};
   logic         exp_brw [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
   logic         exp_ovf [6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};

   initial begin
      int cyc;
      int seen_done;
      rst_ni  = 1'b0;
      start_i = 1'b0;
      a_i     = '0;
      b_i     = '0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_busy",   busy_o,   0);
      check("rst_done",   done_o,   0);
      check("rst_diff",   diff_o,   0);
      check("rst_borrow", borrow_o, 0);
      check("rst_ovf",    ovf_o,    0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // T1-T4 directed vectors
      for (int v = 0; v < 6; v++) begin
         issue(vec_a[v], vec_b[v]);
         check($sformatf("v%0d_busy", v), busy_o, 1);
         wait_done(cyc);
         check($sformatf("v%0d_lat", v),    cyc,      8);
         check($sformatf("v%0d_busyend", v), busy_o,  0);
         check($sformatf("v%0d_diff", v),   diff_o,   exp_d[v]);
         check($sformatf("v%0d_borrow", v), borrow_o, exp_brw[v]);
         check($sformatf("v%0d_ovf", v),    ovf_o,    exp_ovf[v]);
         @(posedge clk_i);
         #1;
         check($sformatf("v%0d_pulse", v), done_o, 0);
      end

      // Results hold in IDLE
      repeat (3) @(posedge clk_i);
      #1;
      check("idle_hold", diff_o, 8'h00);

      // T5: start during RUN ignored, then back-to-back start in DONE cycle
      issue(8'h10, 8'h01);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      start_i = 1'b1;
      a_i     = 8'h20;
      b_i     = 8'h01;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      check("t5_run_hold", diff_o, 8'h00);
      seen_done = 0;
      cyc = MAX_WAIT;
      for (int i = 4; i <= MAX_WAIT; i++) begin
         @(posedge clk_i);
         #1;
         if (done_o) begin
            cyc = i;
            break;
         end
      end
      check("t5_lat",  cyc,    8);
      check("t5_diff", diff_o, 8'h0F);
      start_i = 1'b1;
      a_i     = 8'h20;
      b_i     = 8'h01;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      check("t5_b2b_done_low", done_o, 0);
      check("t5_b2b_busy",     busy_o, 1);
      check("t5_b2b_held",     diff_o, 8'h0F);
      wait_done(cyc);
      check("t5_b2b_lat",    cyc,      8);
      check("t5_b2b_diff",   diff_o,   8'h1F);
      check("t5_b2b_borrow", borrow_o, 0);

      // T6: reset mid-operation aborts with no done
      issue(8'h09, 8'h02);
      repeat (3) @(posedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      check("t6_busy",   busy_o, 0);
      check("t6_done",   done_o, 0);
      check("t6_diff",   diff_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk_i);
         #1;
         if (done_o) seen_done++;
      end
      check("t6_no_done", seen_done, 0);
      issue(8'h09, 8'h02);
      wait_done(cyc);
      check("t6_lat",  cyc,    8);
      check("t6_diff", diff_o, 8'h07);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
